// File: rtl/intreq_nmi_iff.sv
// Interrupt request front end: pin synchronisers, NMI edge latch (TNMI), IFF1/IFF2 with EI shadow, TINT.
// Latency: /NMI to TNMI is SYNC_STAGES+1 edges, strobes act on the edge ending their cycle; no backpressure.
module intreq_nmi_iff #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic not_RESET,
   input  logic not_NMI,
   input  logic not_INT,
   input  logic M1_END,
   input  logic P2_Reset_TNMI,
   input  logic P2_EvacuateIFF,
   input  logic P2_Reset_IFF1,
   input  logic P2_Reset_TINT,
   input  logic Exec_EI,
   input  logic Exec_DI,
   input  logic Exec_RETN,
   output logic TNMI,
   output logic TINT,
   output logic IFF1,
   output logic IFF2
);

   logic [SYNC_STAGES-1:0] nmi_sr;
   logic [SYNC_STAGES-1:0] int_sr;
   logic [SYNC_STAGES-1:0] fill_sr;
   logic                   nmi_sync;
   logic                   int_sync;
   logic                   chain_valid;
   logic                   nmi_prev;
   logic                   nmi_armed;
   logic                   nmi_edge;
   logic                   shadow;
   logic                   block;
   logic                   int_take;
   logic                   iff1_nxt;
   logic                   iff2_nxt;
   logic                   shadow_nxt;

   // fill_sr marks when the synchroniser holds real pin samples rather than reset ones
   always_ff @(posedge CLK or negedge not_RESET) begin
      if (!not_RESET) begin
         nmi_sr  <= '1;
         int_sr  <= '1;
         fill_sr <= '0;
      end else begin
         nmi_sr  <= {nmi_sr[SYNC_STAGES-2:0], not_NMI};
         int_sr  <= {int_sr[SYNC_STAGES-2:0], not_INT};
         fill_sr <= {fill_sr[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign nmi_sync    = nmi_sr[SYNC_STAGES-1];
   assign int_sync    = int_sr[SYNC_STAGES-1];
   assign chain_valid = fill_sr[SYNC_STAGES-1];

   // An edge only counts once /NMI has been seen high after reset, so a pin held low
   // through reset stays silent until it has gone high and low again.
   always_ff @(posedge CLK or negedge not_RESET) begin
      if (!not_RESET) begin
         nmi_prev  <= 1'b1;
         nmi_armed <= 1'b0;
      end else begin
         nmi_prev  <= nmi_sync;
         nmi_armed <= nmi_armed | (chain_valid & nmi_sync);
      end
   end

   assign nmi_edge = nmi_prev & ~nmi_sync & nmi_armed;

   always_ff @(posedge CLK or negedge not_RESET) begin
      if (!not_RESET) begin
         TNMI <= 1'b0;
      end else if (nmi_edge) begin
         TNMI <= 1'b1;
      end else if (P2_Reset_TNMI) begin
         TNMI <= 1'b0;
      end
   end

   assign block    = shadow | Exec_EI;
   assign int_take = M1_END & IFF1 & ~int_sync & ~block & ~TNMI & ~nmi_edge;

   always_comb begin
      iff1_nxt   = IFF1;
      iff2_nxt   = IFF2;
      shadow_nxt = shadow;
      if (P2_EvacuateIFF) begin
         iff2_nxt = IFF1;
         iff1_nxt = 1'b0;
      end else if (P2_Reset_TINT || P2_Reset_IFF1) begin
         iff1_nxt = 1'b0;
         if (P2_Reset_TINT) begin
            iff2_nxt = 1'b0;
         end
      end else if (Exec_DI) begin
         iff1_nxt = 1'b0;
         iff2_nxt = 1'b0;
      end else if (Exec_EI) begin
         iff1_nxt   = 1'b1;
         iff2_nxt   = 1'b1;
         shadow_nxt = 1'b1;
      end else if (Exec_RETN) begin
         iff1_nxt = IFF2;
      end
      // The boundary that ends the EI instruction consumes the shadow, even when EI is on that cycle.
      if (M1_END && block) begin
         shadow_nxt = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge not_RESET) begin
      if (!not_RESET) begin
         IFF1   <= 1'b0;
         IFF2   <= 1'b0;
         shadow <= 1'b0;
      end else begin
         IFF1   <= iff1_nxt;
         IFF2   <= iff2_nxt;
         shadow <= shadow_nxt;
      end
   end

   always_ff @(posedge CLK or negedge not_RESET) begin
      if (!not_RESET) begin
         TINT <= 1'b0;
      end else if (P2_Reset_TINT) begin
         TINT <= 1'b0;
      end else if (int_take) begin
         TINT <= 1'b1;
      end
   end

endmodule

// File: tb/tb_intreq_nmi_iff.sv
// Scoreboard bench for intreq_nmi_iff: expected {TNMI,TINT,IFF1,IFF2} queued with stimulus, compared after each edge.
module tb_intreq_nmi_iff;

   logic CLK = 1'b0;
   logic not_RESET;
   logic not_NMI;
   logic not_INT;
   logic M1_END;
   logic P2_Reset_TNMI;
   logic P2_EvacuateIFF;
   logic P2_Reset_IFF1;
   logic P2_Reset_TINT;
   logic Exec_EI;
   logic Exec_DI;
   logic Exec_RETN;
   logic TNMI;
   logic TINT;
   logic IFF1;
   logic IFF2;
   logic [3:0] outs;

   int n_checks = 0;
   int n_fail   = 0;

   string      tag_q[$];
   logic [3:0] exp_q[$];

   always #5 CLK = ~CLK;

   intreq_nmi_iff #(.SYNC_STAGES(2)) dut (
      .CLK           (CLK),
      .not_RESET     (not_RESET),
      .not_NMI       (not_NMI),
      .not_INT       (not_INT),
      .M1_END        (M1_END),
      .P2_Reset_TNMI (P2_Reset_TNMI),
      .P2_EvacuateIFF(P2_EvacuateIFF),
      .P2_Reset_IFF1 (P2_Reset_IFF1),
      .P2_Reset_TINT (P2_Reset_TINT),
      .Exec_EI       (Exec_EI),
      .Exec_DI       (Exec_DI),
      .Exec_RETN     (Exec_RETN),
      .TNMI          (TNMI),
      .TINT          (TINT),
      .IFF1          (IFF1),
      .IFF2          (IFF2)
   );

   assign outs = {TNMI, TINT, IFF1, IFF2};

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got {TNMI,TINT,IFF1,IFF2}=%b expected %b", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [3:0] exp);
      tag_q.push_back(tag);
      exp_q.push_back(exp);
   endtask

   task automatic sb_drain();
      string      t;
      logic [3:0] e;
      while (exp_q.size() > 0) begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         chk(t, outs, e);
      end
   endtask

   task automatic clear_strobes();
      M1_END         = 1'b0;
      P2_Reset_TNMI  = 1'b0;
      P2_EvacuateIFF = 1'b0;
      P2_Reset_IFF1  = 1'b0;
      P2_Reset_TINT  = 1'b0;
      Exec_EI        = 1'b0;
      Exec_DI        = 1'b0;
      Exec_RETN      = 1'b0;
   endtask

   // Inputs are driven 1 time unit after the rising edge, so strobes cover exactly one cycle.
   task automatic tick();
      @(posedge CLK);
      #1;
      sb_drain();
      clear_strobes();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      not_RESET = 1'b0;
      not_NMI   = 1'b1;
      not_INT   = 1'b1;
      clear_strobes();
      #2;
      expect_out("reset_state", 4'b0000);
      sb_drain();
      tick();
      tick();
      not_RESET = 1'b1;
      repeat (4) tick();

      // NMI falling edge: sampled at E1, TNMI visible after E1+2
      not_NMI = 1'b0;
      expect_out("nmi_lat_e1", 4'b0000); tick();
      expect_out("nmi_lat_e2", 4'b0000); tick();
      expect_out("nmi_lat_e3", 4'b1000); tick();
      P2_Reset_TNMI = 1'b1;
      expect_out("nmi_ack", 4'b0000); tick();
      repeat (20) tick();
      expect_out("nmi_no_retrigger", 4'b0000); tick();
      not_NMI = 1'b1;
      repeat (3) tick();

      // Ack colliding with a fresh edge
      not_NMI = 1'b0;
      tick();
      tick();
      not_NMI = 1'b1;
      tick();
      expect_out("nmi2_pending", 4'b1000); tick();
      repeat (3) tick();
      not_NMI = 1'b0;
      tick();
      tick();
      P2_Reset_TNMI = 1'b1;
      expect_out("ack_edge_collide", 4'b1000); tick();
      P2_Reset_TNMI = 1'b1;
      expect_out("ack_after_collide", 4'b0000); tick();
      not_NMI = 1'b1;
      repeat (3) tick();

      // IFF transfers
      Exec_EI = 1'b1;
      expect_out("ei_sets_iffs", 4'b0011); tick();
      P2_EvacuateIFF = 1'b1; P2_Reset_IFF1 = 1'b1;
      expect_out("evacuate_iff", 4'b0001); tick();
      Exec_RETN = 1'b1;
      expect_out("retn_restore", 4'b0011); tick();
      P2_EvacuateIFF = 1'b1;
      expect_out("evacuate_only", 4'b0001); tick();
      P2_EvacuateIFF = 1'b1;
      expect_out("evacuate_copies_0", 4'b0000); tick();
      Exec_EI = 1'b1; P2_Reset_IFF1 = 1'b1;
      expect_out("reset_iff1_over_ei", 4'b0000); tick();
      Exec_EI = 1'b1;
      tick();
      Exec_DI = 1'b1;
      expect_out("di_clears", 4'b0000); tick();
      M1_END = 1'b1;
      expect_out("shadow_consume", 4'b0000); tick();

      // EI shadow with /INT held low
      not_INT = 1'b0;
      repeat (3) tick();
      Exec_EI = 1'b1; M1_END = 1'b1;
      expect_out("ei_boundary_blocked", 4'b0011); tick();
      M1_END = 1'b1;
      expect_out("int_next_boundary", 4'b0111); tick();
      M1_END = 1'b1;
      expect_out("tint_holds", 4'b0111); tick();
      Exec_DI = 1'b1;
      expect_out("di_keeps_tint", 4'b0100); tick();
      Exec_EI = 1'b1;
      expect_out("ei_with_tint", 4'b0111); tick();
      P2_Reset_TINT = 1'b1;
      expect_out("int_ack", 4'b0000); tick();
      M1_END = 1'b1;
      expect_out("shadow_boundary", 4'b0000); tick();
      M1_END = 1'b1;
      expect_out("int_needs_iff1", 4'b0000); tick();
      not_INT = 1'b1;
      tick();

      // NMI edge on the same boundary as a valid INT
      not_INT = 1'b0;
      Exec_EI = 1'b1;
      tick();
      M1_END = 1'b1;
      expect_out("ei_blocked2", 4'b0011); tick();
      not_NMI = 1'b0;
      tick();
      tick();
      M1_END = 1'b1;
      expect_out("nmi_over_int", 4'b1011); tick();
      M1_END = 1'b1;
      expect_out("tnmi_blocks_int", 4'b1011); tick();
      P2_Reset_TNMI = 1'b1;
      expect_out("nmi_ack2", 4'b0011); tick();
      M1_END = 1'b1;
      expect_out("int_after_nmi", 4'b0111); tick();

      // Async reset with everything set
      not_NMI = 1'b1;
      repeat (3) tick();
      not_NMI = 1'b0;
      tick();
      tick();
      expect_out("all_set", 4'b1111); tick();
      #3;
      not_RESET = 1'b0;
      #1;
      expect_out("async_reset", 4'b0000);
      sb_drain();
      expect_out("reset_held", 4'b0000); tick();
      not_RESET = 1'b1;
      repeat (4) tick();
      expect_out("no_edge_low_at_reset", 4'b0000); tick();
      not_NMI = 1'b1;
      repeat (3) tick();
      not_NMI = 1'b0;
      tick();
      tick();
      expect_out("edge_after_rearm", 4'b1000); tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/intreq_nmi_iff.md
# intreq_nmi_iff

Interrupt request front end for the CPU core. It synchronises the external /NMI and /INT pins, latches a pending NMI on a falling edge (TNMI), and owns the IFF1/IFF2 flip-flops including the EI shadow. It also latches a maskable-interrupt request (TINT) at instruction boundaries. It sits directly upstream of the op-head NMI decoder. It supplies TNMI and consumes the decoder's P2_Reset_TNMI, P2_EvacuateIFF and P2_Reset_IFF1 strobes.

## Interface
- SYNC_STAGES, default 2: pin synchroniser depth, minimum 2.

- CLK  in  1  core clock, rising edge.
- not_RESET  in  1  asynchronous, active-low reset.
- not_NMI  in  1  raw /NMI pin, asynchronous, falling-edge sensitive.
- not_INT  in  1  raw /INT pin, asynchronous, level sensitive, active low.
- M1_END  in  1  one-cycle strobe in the last cycle of every instruction (the instruction boundary).
- P2_Reset_TNMI  in  1  clear TNMI (NMI acknowledged).
- P2_EvacuateIFF  in  1  copy IFF1 into IFF2, then clear IFF1.
- P2_Reset_IFF1  in  1  clear IFF1.
- P2_Reset_TINT  in  1  clear TINT and both IFFs (INT acknowledged).
- Exec_EI, Exec_DI, Exec_RETN  in  1 each  one-cycle execution strobes.
- TNMI  out  1  NMI pending.
- TINT  out  1  maskable interrupt pending.
- IFF1, IFF2  out  1 each  interrupt flip-flops.

## Operation
- **Synchroniser:** each pin passes through SYNC_STAGES flops; these reset to 1.
- **NMI edge detection:**
  - A flop `nmi_prev` (reset 1) holds the previous synchronised /NMI.
  - `nmi_edge = nmi_prev & ~nmi_sync`.
  - A held-low /NMI produces exactly one edge. No further edge occurs until the pin has returned high for at least one synchronised cycle.
- **TNMI:**
  - Set on `nmi_edge`; cleared on P2_Reset_TNMI.
  - If both happen in the same cycle, set wins, so a new edge is never lost.
- **IFF update:** one per cycle, highest priority first.
  1. P2_EvacuateIFF: IFF2 <= IFF1, IFF1 <= 0. A concurrent P2_Reset_IFF1 has no additional effect.
  2. P2_Reset_TINT or P2_Reset_IFF1: P2_Reset_TINT clears IFF1 and IFF2; P2_Reset_IFF1 clears IFF1 only.
  3. Exec_DI: IFF1 <= 0, IFF2 <= 0.
  4. Exec_EI: IFF1 <= 1, IFF2 <= 1, shadow <= 1.
  5. Exec_RETN: IFF1 <= IFF2.
- **EI shadow:**
  - `block = shadow | Exec_EI` (combinational).
  - An M1_END with `block` = 1 clears `shadow` and does not sample /INT.
  - Effect: the boundary ending the EI instruction is blocked; the next boundary may accept an interrupt.
- **TINT sampling:**
  - Condition, evaluated on the M1_END cycle: IFF1 & ~int_sync & ~block & ~TNMI & ~nmi_edge. If true, TINT <= 1 at that edge.
  - NMI has priority: a pending or just-detected NMI suppresses INT at that boundary.
  - TINT holds until P2_Reset_TINT. It is not re-sampled while already 1.
  - Exec_DI or P2_EvacuateIFF while TINT = 1 does not clear TINT.
- /INT deasserted between boundaries is not remembered (level sensitive).

## Timing
- **Reset:** not_RESET low forces all flops immediately.
  - TNMI = 0, TINT = 0, IFF1 = 0, IFF2 = 0, shadow = 0.
  - Synchroniser flops and `nmi_prev` = 1.
  - Reset released with /NMI already low does not produce an edge until /NMI has gone high and then low again.
- **NMI latency:** /NMI sampled low at edge k makes TNMI = 1 after edge k+SYNC_STAGES (k+2 by default).
- **Minimum pulse widths:**
  - /NMI low: one full CLK period to be guaranteed seen.
  - /NMI high between pulses: one full CLK period.
- **INT latency:** /INT must be low at the synchroniser input SYNC_STAGES cycles before the M1_END cycle. TINT rises on the edge ending that M1_END cycle.
- **Other outputs:** all IFF/TINT/TNMI updates take effect on the edge ending the strobe cycle. Every output is a flop output.

## Test plan
- **Reset and NMI edge:** reset, release, pulse not_NMI low 3 cycles.
  - TNMI = 1 exactly 2 edges after first low sample.
  - Holding low 20 more cycles after P2_Reset_TNMI gives TNMI = 0 (no retrigger).
- **Ack/edge collision:** new NMI edge in the same cycle as P2_Reset_TNMI -> TNMI stays 1.
- **NMI entry and RETN:**
  - Start from IFF1 = 1, IFF2 = 0 (after EI, then set IFF2 = 0 via P2_Reset_IFF1-free sequence: EI, EvacuateIFF, RETN as required).
  - Strobe P2_EvacuateIFF + P2_Reset_IFF1 together -> IFF1 = 0, IFF2 = 1.
  - Then Exec_RETN -> IFF1 = 1.
- **EI shadow:** not_INT held low, Exec_EI together with M1_END.
  - TINT = 0 after that boundary.
  - TINT = 1 after the following M1_END.
  - P2_Reset_TINT -> TINT = 0, IFF1 = IFF2 = 0.
- **NMI priority over INT:** IFF1 = 1, not_INT low, NMI edge in the same cycle as M1_END -> TNMI = 1, TINT = 0.
- **Async reset mid-operation:** assert not_RESET between CLK edges while TNMI = 1, TINT = 1, IFF1 = 1 -> all outputs 0 immediately, without waiting for a clock edge.
